core_wb_arbiter: RTL

// Shares the two register-file write ports among the five execution units fed by dispatch
// (alu_a, alu_b, mul, ldst, branch). The ALUs have fixed priority on their own ports.
// mul/ldst/branch compete round-robin for the ports left free; each has a one-entry skid buffer.

---
 rtl/core_wb_arbiter_pkg.sv | 41 ++++
 rtl/core_wb_arbiter_if.sv | 54 +++++
 rtl/core_wb_arbiter_skid.sv | 51 +++++
 rtl/core_wb_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/core_wb_arbiter_pkg.sv
// rtl/core_wb_arbiter_pkg.sv - shared types and helpers for the writeback-port arbiter
package core_wb_arbiter_pkg;

  localparam int WORD_W = 32;
  localparam int NREGS  = 16;
  localparam int RD_W   = $clog2(NREGS);
  localparam int NUNITS = 3;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [RD_W-1:0]   reg_num_t;
  typedef logic [NREGS-1:0]  hword_t;

  typedef struct packed {
    logic     valid;
    reg_num_t rd;
    word_t    value;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_MUL    = 2'd0,
    WB_LDST   = 2'd1,
    WB_BRANCH = 2'd2
  } wb_unit_t;

  function automatic hword_t rd_onehot(input reg_num_t rd);
    hword_t m;
    m     = '0;
    m[rd] = 1'b1;
    return m;
  endfunction

  // Round-robin successor: mul -> ldst -> branch -> mul
  function automatic wb_unit_t unit_next(input wb_unit_t u);
    case (u)
      WB_MUL:  return WB_LDST;
      WB_LDST: return WB_BRANCH;
      default: return WB_MUL;
    endcase
  endfunction

endpackage

// File: rtl/core_wb_arbiter_if.sv
// rtl/core_wb_arbiter_if.sv - execution-unit results in, register-file write ports and stalls out
interface core_wb_arbiter_if;
  import core_wb_arbiter_pkg::*;

  logic     alu_a_valid;
  reg_num_t alu_a_rd;
  word_t    alu_a_value;
  logic     alu_b_valid;
  reg_num_t alu_b_rd;
  word_t    alu_b_value;
  logic     mul_valid;
  reg_num_t mul_rd;
  word_t    mul_value;
  logic     ldst_valid;
  reg_num_t ldst_rd;
  word_t    ldst_value;
  logic     branch_valid;
  reg_num_t branch_rd;
  word_t    branch_value;

  logic     stall_mul;
  logic     stall_ldst;
  logic     wb_stall_branch;
  logic     wr_en_0;
  logic     wr_en_1;
  reg_num_t wr_r_0;
  reg_num_t wr_r_1;
  word_t    wr_value_0;
  word_t    wr_value_1;
  hword_t   pending_mask;

  modport master (
    output alu_a_valid, alu_a_rd, alu_a_value,
    output alu_b_valid, alu_b_rd, alu_b_value,
    output mul_valid, mul_rd, mul_value,
    output ldst_valid, ldst_rd, ldst_value,
    output branch_valid, branch_rd, branch_value,
    input  stall_mul, stall_ldst, wb_stall_branch,
    input  wr_en_0, wr_en_1, wr_r_0, wr_r_1, wr_value_0, wr_value_1,
    input  pending_mask
  );

  modport slave (
    input  alu_a_valid, alu_a_rd, alu_a_value,
    input  alu_b_valid, alu_b_rd, alu_b_value,
    input  mul_valid, mul_rd, mul_value,
    input  ldst_valid, ldst_rd, ldst_value,
    input  branch_valid, branch_rd, branch_value,
    output stall_mul, stall_ldst, wb_stall_branch,
    output wr_en_0, wr_en_1, wr_r_0, wr_r_1, wr_value_0, wr_value_1,
    output pending_mask
  );

endinterface

// File: rtl/core_wb_arbiter_skid.sv
// rtl/core_wb_arbiter_skid.sv - one-entry skid buffer holding an ungranted unit result
module core_wb_skid
  import core_wb_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  wb_req_t i_live,
  input  logic    i_grant,
  output wb_req_t o_cand,
  output logic    o_full
);

  logic     r_full;
  reg_num_t r_rd;
  word_t    r_value;
  logic     w_capture;

  // While full the unit is stalled, so a live request is ignored outright
  assign w_capture = i_live.valid && !r_full && !i_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
    end else if (r_full) begin
      r_full <= !i_grant;
    end else begin
      r_full <= w_capture;
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_rd    <= i_live.rd;
      r_value <= i_live.value;
    end
  end

  always_comb begin
    o_cand = i_live;
    if (r_full) begin
      o_cand = '{valid: 1'b1, rd: r_rd, value: r_value};
    end
  end

  assign o_full = r_full;

  a_no_valid_while_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(i_live.valid && r_full)
  );

endmodule

// File: rtl/core_wb_arbiter.sv
// rtl/core_wb_arbiter.sv - shares the two register-file write ports among five execution units
module core_wb_arbiter
  import core_wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  core_wb_arbiter_if.slave  wb
);

  wb_req_t           w_live [NUNITS];
  wb_req_t           w_cand [NUNITS];
  logic [NUNITS-1:0] w_full;
  logic [NUNITS-1:0] w_grant;
  wb_req_t           w_port_0;
  wb_req_t           w_port_1;
  hword_t            w_used;
  hword_t            w_pending;
  wb_unit_t          w_scan;
  wb_unit_t          r_rr;
  wb_unit_t          w_rr_next;

  logic              r_wr_en_0;
  logic              r_wr_en_1;
  reg_num_t          r_wr_r_0;
  reg_num_t          r_wr_r_1;
  word_t             r_wr_value_0;
  word_t             r_wr_value_1;

  assign w_live[0] = '{valid: wb.mul_valid,    rd: wb.mul_rd,    value: wb.mul_value};
  assign w_live[1] = '{valid: wb.ldst_valid,   rd: wb.ldst_rd,   value: wb.ldst_value};
  assign w_live[2] = '{valid: wb.branch_valid, rd: wb.branch_rd, value: wb.branch_value};

  for (genvar g = 0; g < NUNITS; g++) begin : g_skid
    core_wb_skid u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_live  (w_live[g]),
      .i_grant (w_grant[g]),
      .o_cand  (w_cand[g]),
      .o_full  (w_full[g])
    );
  end

  // ALUs own their ports; the scan fills what they leave, skipping any rd already written
  always_comb begin
    w_grant   = '0;
    w_rr_next = r_rr;
    w_port_0  = '{valid: wb.alu_a_valid, rd: wb.alu_a_rd, value: wb.alu_a_value};
    w_port_1  = '{valid: wb.alu_b_valid, rd: wb.alu_b_rd, value: wb.alu_b_value};
    w_used    = '0;
    if (wb.alu_a_valid) w_used = w_used | rd_onehot(wb.alu_a_rd);
    if (wb.alu_b_valid) w_used = w_used | rd_onehot(wb.alu_b_rd);
    w_scan = r_rr;
    for (int k = 0; k < NUNITS; k++) begin
      if (w_cand[w_scan].valid && !w_used[w_cand[w_scan].rd]) begin
        if (!w_port_0.valid) begin
          w_port_0        = w_cand[w_scan];
          w_grant[w_scan] = 1'b1;
          w_used          = w_used | rd_onehot(w_cand[w_scan].rd);
          w_rr_next       = unit_next(w_scan);
        end else if (!w_port_1.valid) begin
          w_port_1        = w_cand[w_scan];
          w_grant[w_scan] = 1'b1;
          w_used          = w_used | rd_onehot(w_cand[w_scan].rd);
          w_rr_next       = unit_next(w_scan);
        end
      end
      w_scan = unit_next(w_scan);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= WB_MUL;
    end else begin
      r_rr <= w_rr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en_0 <= 1'b0;
      r_wr_en_1 <= 1'b0;
    end else begin
      r_wr_en_0 <= w_port_0.valid;
      r_wr_en_1 <= w_port_1.valid;
    end
  end

  always_ff @(posedge clk) begin
    r_wr_r_0     <= w_port_0.rd;
    r_wr_r_1     <= w_port_1.rd;
    r_wr_value_0 <= w_port_0.value;
    r_wr_value_1 <= w_port_1.value;
  end

  always_comb begin
    w_pending = '0;
    for (int k = 0; k < NUNITS; k++) begin
      if (w_full[k]) w_pending = w_pending | rd_onehot(w_cand[k].rd);
    end
  end

  assign wb.stall_mul       = w_full[0];
  assign wb.stall_ldst      = w_full[1];
  assign wb.wb_stall_branch = w_full[2];
  assign wb.wr_en_0         = r_wr_en_0;
  assign wb.wr_en_1         = r_wr_en_1;
  assign wb.wr_r_0          = r_wr_r_0;
  assign wb.wr_r_1          = r_wr_r_1;
  assign wb.wr_value_0      = r_wr_value_0;
  assign wb.wr_value_1      = r_wr_value_1;
  assign wb.pending_mask    = w_pending;

  a_alu_rd_distinct: assert property (
    @(posedge clk) disable iff (!rst_n)
      !(wb.alu_a_valid && wb.alu_b_valid && (wb.alu_a_rd == wb.alu_b_rd))
  );

endmodule
